counter_read_logic: RTL and testbench
=====================================

# counter_read_logic

Read-back path for one 8253 counter: the CPU-facing reader that complements the control word write path. It holds the counter's RW/Mode/BCD setting, captures counter-latch (and optionally status-latch) commands, and sequences LSB/MSB bytes onto the read data path across successive CPU reads. One instance sits beside each of the three counters, between the counter core and the bus interface's read multiplexer.

## Interface
- No parameters.
- Clk  input  1  system clock; all state updates on rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- ControlWordLoad  input  1  one-cycle pulse: new control word written for this counter.
- ControlWord  input  6  {RW[5:4], Mode[3:1], BCD[0]}; sampled on ControlWordLoad.
- LatchCount  input  1  one-cycle pulse: counter-latch command for this counter.
- LatchStatus  input  1  one-cycle pulse: status-latch command (see Configuration).
- ReadStrobe  input  1  one-cycle pulse: end of one CPU read of this counter; consumes the current byte.
- CountValue  input  16  live count from the counter core.
- OutPin  input  1  counter OUT level, for the status byte.
- NullCount  input  1  null-count flag from the counter core, for the status byte.
- DataOut  output  8  byte the next CPU read returns (registered).
- CountLatched  output  1  latched count is held and not yet fully read.
- StatusLatched  output  1  latched status is held and not yet read.
- MsbNext  output  1  in RW=11, next count byte is the MSB.

## Operation
- Registers: Rw[1:0], Mode[2:0], Bcd, MsbNext, CountLatched, LatchedCount[15:0], StatusLatched, StatusByte[7:0].
- ControlWordLoad with RW!=00: store RW/Mode/Bcd; clear MsbNext, CountLatched, StatusLatched. ControlWordLoad with RW=00: ignored (latch decode belongs to the write side). Highest priority; same-cycle ReadStrobe/LatchCount/LatchStatus ignored.
- Count source: LatchedCount if CountLatched, else live CountValue.
- Byte selection: StatusLatched -> StatusByte; else RW=01 -> source[7:0]; RW=10 -> source[15:8]; RW=11 -> MsbNext ? source[15:8] : source[7:0].
- ReadStrobe: if StatusLatched, clear StatusLatched only. Else RW=11 toggles MsbNext; a read completing the count (RW=01/10 any read, RW=11 MSB read) clears CountLatched.
- LatchCount: if CountLatched is 0 after this cycle's read update, capture CountValue into LatchedCount, set CountLatched; otherwise ignored (first latch wins until fully read). MsbNext unchanged.
- LatchStatus: if StatusLatched is 0 after read update, capture StatusByte = {OutPin, NullCount, Rw, Mode, Bcd}, set StatusLatched; else ignored.
- Same-cycle order: load, then read, then latches evaluated on post-read state.
- Unlatched RW=11 reads: LSB and MSB each taken from live count at their own read (no coherency, as 8253).

## Timing
- Reset: Rw=11, Mode=000, Bcd=0, MsbNext=0, CountLatched=0, StatusLatched=0, LatchedCount=0, StatusByte=0, DataOut=0x00.
- DataOut registered: reflects state and CountValue sampled at the previous edge; one-cycle latency after any event or count change.
- Flags update on the edge that samples the strobe.
- ReadStrobe asserted for consecutive cycles counts as consecutive reads.
- Reset mid-sequence (e.g. after LSB read): all state returns to reset values immediately, no partial byte retained.

## Configuration
- STATUS_READBACK_EN defined: status latch, StatusByte and StatusLatched behave as above.
- Not defined: LatchStatus ignored, StatusLatched tied 0, StatusByte logic absent; OutPin/NullCount unused.

## Test plan
- Reset, load CW 0x30 (RW=11), CountValue=0x1234, LatchCount, change CountValue to 0x5678, two reads -> DataOut 0x34 then 0x12; CountLatched clears after second read; next reads 0x78,0x56.
- RW=11, CountValue=0xABCD, LatchCount, second LatchCount at 0x1111 before reading -> reads 0xCD, 0xAB (second latch ignored).
- RW=01 then RW=10 with CountValue=0xBEEF, LatchCount, one read each -> 0xEF resp. 0xBE; CountLatched clears after one read.
- With macro: CW 0x36 (RW=11, Mode=3), OutPin=1, NullCount=0, LatchStatus+LatchCount same cycle, CountValue=0x0102 -> reads 0xB6, 0x02, 0x01.
- RW=11, read LSB only, then ControlWordLoad 0x30 -> MsbNext=0, next read returns LSB; same test with Rst_n pulse mid-sequence -> DataOut 0x00, all flags 0.
- Without macro: LatchStatus pulse -> StatusLatched stays 0, next read returns count LSB.

Source files
------------

// File: rtl/counter_read_logic.sv
// counter_read_logic
// Read-back path for one 8253 counter. Holds the counter's RW/Mode/BCD
// setting, captures counter-latch (and optionally status-latch) commands, and
// sequences LSB/MSB bytes onto DataOut across successive CPU reads.
//
// Optional feature macro: STATUS_READBACK_EN
//   defined   : LatchStatus captures {OutPin, NullCount, RW, Mode, BCD} and the
//               next read returns that status byte ahead of any count byte.
//   undefined : LatchStatus, OutPin and NullCount are ignored and StatusLatched
//               is tied low.
//
// Ports
//   Clk, Rst_n       clock, asynchronous active-low reset
//   ControlWordLoad  pulse: ControlWord {RW[5:4], Mode[3:1], BCD[0]} is valid
//   LatchCount       pulse: counter-latch command
//   LatchStatus      pulse: status-latch command
//   ReadStrobe       pulse: a CPU read completed, consume the current byte
//   CountValue       live count from the counter core
//   OutPin/NullCount status bits from the counter core
//   DataOut          registered byte returned by the next CPU read
//   CountLatched     latched count held and not yet fully read
//   StatusLatched    latched status held and not yet read
//   MsbNext          in RW=11, the next count byte is the MSB
module counter_read_logic (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ControlWordLoad,
  input  logic [5:0]  ControlWord,
  input  logic        LatchCount,
  input  logic        LatchStatus,
  input  logic        ReadStrobe,
  input  logic [15:0] CountValue,
  input  logic        OutPin,
  input  logic        NullCount,
  output logic [7:0]  DataOut,
  output logic        CountLatched,
  output logic        StatusLatched,
  output logic        MsbNext
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned RW_W   = 2;
  localparam int unsigned MODE_W = 3;

  localparam logic [RW_W-1:0] RW_LATCH = 2'b00;
  localparam logic [RW_W-1:0] RW_LSB   = 2'b01;
  localparam logic [RW_W-1:0] RW_MSB   = 2'b10;
  localparam logic [RW_W-1:0] RW_WORD  = 2'b11;

  logic [RW_W-1:0]   rw_q, rw_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              bcd_q, bcd_d;
  logic              msb_next_q, msb_next_d;
  logic              count_latched_q, count_latched_d;
  logic [CNT_W-1:0]  latched_count_q, latched_count_d;
  logic [BYTE_W-1:0] data_out_q, data_out_d;

  logic              load_c;
  logic              status_held_c;
  logic              count_read_c;
  logic [CNT_W-1:0]  count_src_c;

  // A control word with RW=00 is a latch command decoded on the write side.
  assign load_c = ControlWordLoad && (ControlWord[5:4] != RW_LATCH);

`ifdef STATUS_READBACK_EN
  logic              status_latched_q, status_latched_d;
  logic [BYTE_W-1:0] status_byte_q, status_byte_d;

  assign status_held_c = status_latched_q;
`else
  logic unused_status_inputs;

  assign status_held_c        = 1'b0;
  assign unused_status_inputs = ^{LatchStatus, OutPin, NullCount, mode_q, bcd_q};
`endif

  // A pending status byte absorbs the read; otherwise the read consumes a count byte.
  assign count_read_c = ReadStrobe && !status_held_c;

  // Next-state: load first, then read, then latches on the post-read flags.
  always_comb begin
    rw_d            = rw_q;
    mode_d          = mode_q;
    bcd_d           = bcd_q;
    msb_next_d      = msb_next_q;
    count_latched_d = count_latched_q;
    latched_count_d = latched_count_q;
`ifdef STATUS_READBACK_EN
    status_latched_d = status_latched_q;
    status_byte_d    = status_byte_q;
`endif

    if (load_c) begin
      rw_d            = ControlWord[5:4];
      mode_d          = ControlWord[3:1];
      bcd_d           = ControlWord[0];
      msb_next_d      = 1'b0;
      count_latched_d = 1'b0;
`ifdef STATUS_READBACK_EN
      status_latched_d = 1'b0;
`endif
    end else begin
`ifdef STATUS_READBACK_EN
      if (ReadStrobe && status_latched_q) begin
        status_latched_d = 1'b0;
      end
`endif
      if (count_read_c) begin
        if (rw_q == RW_WORD) begin
          msb_next_d = !msb_next_q;
          // Only the MSB read completes a 16-bit count.
          if (msb_next_q) begin
            count_latched_d = 1'b0;
          end
        end else begin
          count_latched_d = 1'b0;
        end
      end

      // First latch wins until the held count has been fully read.
      if (LatchCount && !count_latched_d) begin
        latched_count_d = CountValue;
        count_latched_d = 1'b1;
      end

`ifdef STATUS_READBACK_EN
      if (LatchStatus && !status_latched_d) begin
        status_byte_d    = {OutPin, NullCount, rw_q, mode_q, bcd_q};
        status_latched_d = 1'b1;
      end
`endif
    end
  end

  // Byte the next read returns, from the state before this edge.
  always_comb begin
    count_src_c = count_latched_q ? latched_count_q : CountValue;
    data_out_d  = count_src_c[7:0];
    unique case (rw_q)
      RW_LSB:  data_out_d = count_src_c[7:0];
      RW_MSB:  data_out_d = count_src_c[15:8];
      default: data_out_d = msb_next_q ? count_src_c[15:8] : count_src_c[7:0];
    endcase
`ifdef STATUS_READBACK_EN
    if (status_latched_q) begin
      data_out_d = status_byte_q;
    end
`endif
  end

  // State registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rw_q            <= RW_WORD;
      mode_q          <= MODE_W'(0);
      bcd_q           <= 1'b0;
      msb_next_q      <= 1'b0;
      count_latched_q <= 1'b0;
      latched_count_q <= CNT_W'(0);
      data_out_q      <= BYTE_W'(0);
    end else begin
      rw_q            <= rw_d;
      mode_q          <= mode_d;
      bcd_q           <= bcd_d;
      msb_next_q      <= msb_next_d;
      count_latched_q <= count_latched_d;
      latched_count_q <= latched_count_d;
      data_out_q      <= data_out_d;
    end
  end

`ifdef STATUS_READBACK_EN
  // Status capture registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      status_latched_q <= 1'b0;
      status_byte_q    <= BYTE_W'(0);
    end else begin
      status_latched_q <= status_latched_d;
      status_byte_q    <= status_byte_d;
    end
  end

  assign StatusLatched = status_latched_q;
`else
  assign StatusLatched = 1'b0;
`endif

  assign DataOut      = data_out_q;
  assign CountLatched = count_latched_q;
  assign MsbNext      = msb_next_q;

endmodule

// File: tb/tb_counter_read_logic.sv
// Testbench for counter_read_logic: directed scenarios with constant expected
// bytes, followed by randomized traffic checked against a byte-queue model.
`timescale 1ns/1ps
module tb_counter_read_logic;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cwl = 1'b0;
  logic [5:0]  cw = 6'h00;
  logic        lc = 1'b0;
  logic        ls = 1'b0;
  logic        rs = 1'b0;
  logic [15:0] cv = 16'h0000;
  logic        out_pin = 1'b0;
  logic        null_count = 1'b0;
  logic [7:0]  dout;
  logic        count_latched;
  logic        status_latched;
  logic        msb_next;

  int checks = 0;
  int errors = 0;

`ifdef STATUS_READBACK_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  counter_read_logic dut (
    .Clk            (clk),
    .Rst_n          (rst_n),
    .ControlWordLoad(cwl),
    .ControlWord    (cw),
    .LatchCount     (lc),
    .LatchStatus    (ls),
    .ReadStrobe     (rs),
    .CountValue     (cv),
    .OutPin         (out_pin),
    .NullCount      (null_count),
    .DataOut        (dout),
    .CountLatched   (count_latched),
    .StatusLatched  (status_latched),
    .MsbNext        (msb_next)
  );

  always #5 clk = ~clk;

  // Reference model: bytes still owed to the CPU are kept as queues.
  logic [1:0] m_rw;
  logic [2:0] m_mode;
  logic       m_bcd;
  logic       m_msb;
  logic [7:0] m_cnt[$];
  logic [7:0] m_stat[$];
  logic [7:0] exp_dout;

  task automatic model_reset();
    m_rw = 2'd3; m_mode = 3'd0; m_bcd = 1'b0; m_msb = 1'b0;
    m_cnt.delete();
    m_stat.delete();
  endtask

  function automatic logic [7:0] model_byte();
    if (m_stat.size() != 0) return m_stat[0];
    if (m_cnt.size() != 0) return m_cnt[0];
    if (m_rw == 2'd1) return cv[7:0];
    if (m_rw == 2'd2) return cv[15:8];
    return m_msb ? cv[15:8] : cv[7:0];
  endfunction

  task automatic model_step();
    if (cwl && cw[5:4] != 2'd0) begin
      m_rw = cw[5:4]; m_mode = cw[3:1]; m_bcd = cw[0]; m_msb = 1'b0;
      m_cnt.delete();
      m_stat.delete();
      return;
    end
    if (rs) begin
      if (m_stat.size() != 0) void'(m_stat.pop_front());
      else begin
        if (m_cnt.size() != 0) void'(m_cnt.pop_front());
        if (m_rw == 2'd3) m_msb = !m_msb;
      end
    end
    if (lc && m_cnt.size() == 0) begin
      if (m_rw == 2'd1) m_cnt.push_back(cv[7:0]);
      else if (m_rw == 2'd2) m_cnt.push_back(cv[15:8]);
      else begin
        if (!m_msb) m_cnt.push_back(cv[7:0]);
        m_cnt.push_back(cv[15:8]);
      end
    end
    if (STATUS_EN && ls && m_stat.size() == 0)
      m_stat.push_back({out_pin, null_count, m_rw, m_mode, m_bcd});
  endtask

  // One clock with the given strobes; leaves time at posedge + 1.
  task automatic cyc(input logic i_cwl, input logic [5:0] i_cw,
                     input logic i_lc, input logic i_ls, input logic i_rs);
    cwl = i_cwl; cw = i_cw; lc = i_lc; ls = i_ls; rs = i_rs;
    exp_dout = model_byte();
    @(posedge clk);
    #1;
    model_step();
    cwl = 1'b0; lc = 1'b0; ls = 1'b0; rs = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cv = 16'h1234;
    #12;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    checks++; if (count_latched !== 1'b0) begin errors++; $display("FAIL reset_cl: got %b expected 0", count_latched); end
    checks++; if (status_latched !== 1'b0) begin errors++; $display("FAIL reset_sl: got %b expected 0", status_latched); end
    checks++; if (msb_next !== 1'b0) begin errors++; $display("FAIL reset_msb: got %b expected 0", msb_next); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    checks++; if (dout !== 8'h34) begin errors++; $display("FAIL reset_first_byte: got %h expected 34", dout); end
  endtask

  task automatic test_latch_word();
    cv = 16'h1234;
    cyc(1'b1, 6'h30, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
    cv = 16'h5678;
    idle();
    checks++; if (dout !== 8'h34) begin errors++; $display("FAIL word_lsb: got %h expected 34", dout); end
    checks++; if (count_latched !== 1'b1) begin errors++; $display("FAIL word_cl_set: got %b expected 1", count_latched); end
    cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    idle();
    checks++; if (dout !== 8'h12) begin errors++; $display("FAIL word_msb: got %h expected 12", dout); end
    checks++; if (count_latched !== 1'b1) begin errors++; $display("FAIL word_cl_mid: got %b expected 1", count_latched); end
    cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (count_latched !== 1'b0) begin errors++; $display("FAIL word_cl_clr: got %b expected 0", count_latched); end
    idle();
    checks++; if (dout !== 8'h78) begin errors++; $display("FAIL word_live_lsb: got %h expected 78", dout); end
    cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    idle();
    checks++; if (dout !== 8'h56) begin errors++; $display("FAIL word_live_msb: got %h expected 56", dout); end
  endtask

  task automatic test_double_latch();
    cv = 16'hABCD;
    cyc(1'b1, 6'h30, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
    cv = 16'h1111;
    cyc(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
    idle();
    checks++; if (dout !== 8'hCD) begin errors++; $display("FAIL dbl_lsb: got %h expected cd", dout); end
    cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    idle();
    checks++; if (dout !== 8'hAB) begin errors++; $display("FAIL dbl_msb: got %h expected ab", dout); end
    cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (count_latched !== 1'b0) begin errors++; $display("FAIL dbl_cl_clr: got %b expected 0", count_latched); end
  endtask

  task automatic test_single_byte();
    cv = 16'hBEEF;
    cyc(1'b1, 6'h10, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
    cv = 16'h2222;
    idle();
    checks++; if (dout !== 8'hEF) begin errors++; $display("FAIL rw01_byte: got %h expected ef", dout); end
    cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (count_latched !== 1'b0) begin errors++; $display("FAIL rw01_cl_clr: got %b expected 0", count_latched); end
    cv = 16'hBEEF;
    cyc(1'b1, 6'h20, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
    cv = 16'h3333;
    idle();
    checks++; if (dout !== 8'hBE) begin errors++; $display("FAIL rw10_byte: got %h expected be", dout); end
    cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (count_latched !== 1'b0) begin errors++; $display("FAIL rw10_cl_clr: got %b expected 0", count_latched); end
  endtask

`ifdef STATUS_READBACK_EN
  task automatic test_status();
    cv = 16'h0102;
    out_pin = 1'b1;
    null_count = 1'b0;
    cyc(1'b1, 6'h36, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b1, 1'b1, 1'b0);
    idle();
    checks++; if (dout !== 8'hB6) begin errors++; $display("FAIL status_byte: got %h expected b6", dout); end
    checks++; if (status_latched !== 1'b1) begin errors++; $display("FAIL status_sl_set: got %b expected 1", status_latched); end
    cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (status_latched !== 1'b0) begin errors++; $display("FAIL status_sl_clr: got %b expected 0", status_latched); end
    checks++; if (msb_next !== 1'b0) begin errors++; $display("FAIL status_msb_kept: got %b expected 0", msb_next); end
    idle();
    checks++; if (dout !== 8'h02) begin errors++; $display("FAIL status_lsb: got %h expected 02", dout); end
    cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    idle();
    checks++; if (dout !== 8'h01) begin errors++; $display("FAIL status_msb: got %h expected 01", dout); end
    cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (count_latched !== 1'b0) begin errors++; $display("FAIL status_cl_clr: got %b expected 0", count_latched); end
  endtask
`else
  task automatic test_no_status();
    cv = 16'h4455;
    out_pin = 1'b1;
    cyc(1'b1, 6'h30, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (status_latched !== 1'b0) begin errors++; $display("FAIL nostat_sl: got %b expected 0", status_latched); end
    idle();
    checks++; if (dout !== 8'h55) begin errors++; $display("FAIL nostat_lsb: got %h expected 55", dout); end
    cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    idle();
    checks++; if (dout !== 8'h44) begin errors++; $display("FAIL nostat_msb: got %h expected 44", dout); end
  endtask
`endif

  task automatic test_reload_and_reset();
    cv = 16'h9A7B;
    cyc(1'b1, 6'h30, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (msb_next !== 1'b1) begin errors++; $display("FAIL reload_msb_set: got %b expected 1", msb_next); end
    cyc(1'b1, 6'h30, 1'b0, 1'b0, 1'b0);
    checks++; if (msb_next !== 1'b0) begin errors++; $display("FAIL reload_msb_clr: got %b expected 0", msb_next); end
    idle();
    checks++; if (dout !== 8'h7B) begin errors++; $display("FAIL reload_lsb: got %h expected 7b", dout); end
    cyc(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (msb_next !== 1'b1) begin errors++; $display("FAIL midrst_msb_set: got %b expected 1", msb_next); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midrst_dout: got %h expected 00", dout); end
    checks++; if (count_latched !== 1'b0) begin errors++; $display("FAIL midrst_cl: got %b expected 0", count_latched); end
    checks++; if (msb_next !== 1'b0) begin errors++; $display("FAIL midrst_msb: got %b expected 0", msb_next); end
    checks++; if (status_latched !== 1'b0) begin errors++; $display("FAIL midrst_sl: got %b expected 0", status_latched); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (dout !== 8'h7B) begin errors++; $display("FAIL midrst_after: got %h expected 7b", dout); end
  endtask

  task automatic test_random();
    logic [5:0] r_cw;
    int unsigned r;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) cv = 16'($urandom);
      out_pin    = 1'($urandom);
      null_count = 1'($urandom);
      r = $urandom_range(0, 99);
      r_cw = 6'($urandom);
      if (r < 5) begin
        r_cw[5:4] = 2'($urandom_range(1, 3));
        cyc(1'b1, r_cw, 1'($urandom), 1'($urandom), 1'($urandom));
      end else if (r < 8) begin
        r_cw[5:4] = 2'd0;
        cyc(1'b1, r_cw, 1'b0, 1'b0, 1'b0);
      end else begin
        cyc(1'b0, 6'h00, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 1) == 0));
      end
      checks++; if (dout !== exp_dout) begin errors++; $display("FAIL rand_dout[%0d]: got %h expected %h", i, dout, exp_dout); end
      checks++; if (count_latched !== (m_cnt.size() != 0)) begin errors++; $display("FAIL rand_cl[%0d]: got %b expected %b", i, count_latched, (m_cnt.size() != 0)); end
      checks++; if (status_latched !== (m_stat.size() != 0)) begin errors++; $display("FAIL rand_sl[%0d]: got %b expected %b", i, status_latched, (m_stat.size() != 0)); end
      checks++; if (msb_next !== m_msb) begin errors++; $display("FAIL rand_msb[%0d]: got %b expected %b", i, msb_next, m_msb); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latch_word();
    test_double_latch();
    test_single_byte();
`ifdef STATUS_READBACK_EN
    test_status();
`else
    test_no_status();
`endif
    test_reload_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
